// File: rtl/uart_tx_cfg_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Encodings, FSM state type and helpers for the uart_tx_cfg block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_e;

  typedef enum logic [1:0] {
    STOP_0P5 = 2'd0,
    STOP_1   = 2'd1,
    STOP_1P5 = 2'd2,
    STOP_2   = 2'd3
  } stopbits_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Reserved encodings 5..7 behave as "no parity".
  function automatic parity_e sanitize_parity(input logic [2:0] mode);
    return (mode > 3'd4) ? PAR_NONE : parity_e'(mode);
  endfunction

  function automatic logic parity_bit(input parity_e mode, input logic data_xor);
    case (mode)
      PAR_EVEN: return data_xor;
      PAR_ODD:  return ~data_xor;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_cfg_if.sv
// ============================================================================
// Module  : uart_tx_cfg_if
// Brief   : Configuration, write-side handshake and serial outputs of the TX.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_cfg_if #(
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [CNT_W-1:0]  bit_duration;
  logic [2:0]        parity_mode;
  logic [1:0]        stopbits;
  logic              msb_first;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              tx;
  logic              tx_done;
  logic              busy;
  logic [LVL_W-1:0]  fifo_level;

  modport master (
    output bit_duration, parity_mode, stopbits, msb_first, in_data, in_valid,
    input  in_ready, tx, tx_done, busy, fifo_level
  );

  modport slave (
    input  bit_duration, parity_mode, stopbits, msb_first, in_data, in_valid,
    output in_ready, tx, tx_done, busy, fifo_level
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_cfg_fifo.sv
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : Synchronous FIFO with registered read data and occupancy output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     push_i,
  input  wire logic [DATA_W-1:0]        data_i,
  input  wire logic                     pop_i,
  output      logic [DATA_W-1:0]        data_o,
  output      logic [$clog2(DEPTH):0]   level_o,
  output      logic                     full_o
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic [DATA_W-1:0] data_q;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && (level_q != '0);
  assign level_o = level_q;
  assign data_o  = data_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      data_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        data_q   <= mem_q[rd_ptr_q];
      end
      if (do_push && !do_pop)      level_q <= level_q + LVL_W'(1);
      else if (!do_push && do_pop) level_q <= level_q - LVL_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_cfg.sv
// ============================================================================
// Module  : uart_tx_cfg
// Brief   : Buffered UART transmitter with per-frame parity/stop/order config.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input wire logic    clk,
  input wire logic    rst,
  uart_tx_cfg_if.slave bus
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = $clog2(DATA_W);
  localparam int SW    = CNT_W + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bd_q, cnt_q, cnt_d;
  logic [SW-1:0]     stop_len_q, scnt_q, scnt_d, stop_len_w;
  logic [IDX_W-1:0]  idx_q, idx_d;
  parity_e           par_mode_q;
  logic              msb_first_q, par_bit_q;
  logic [DATA_W-1:0] shreg_q, fifo_data;
  logic [LVL_W-1:0]  level;
  logic              full, push, pop, fifo_nonempty;
  logic              bit_end, stop_end, last_bit, load_word;
  logic              tx_w, tx_done_w, busy_w;

  assign fifo_nonempty = (level != '0);
  assign push          = bus.in_valid && !full;
  assign bit_end       = (cnt_q == bd_q - CNT_W'(1));
  assign stop_end      = (scnt_q == stop_len_q - SW'(1));
  assign last_bit      = (idx_q == IDX_W'(DATA_W - 1));
  assign pop           = fifo_nonempty &&
                         ((state_q == S_IDLE) || (state_q == S_STOP && stop_end));
  // Read data is registered, so the word lands in the shifter on the first START cycle.
  assign load_word     = (state_q == S_START) && (cnt_q == '0);

  uart_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (bus.in_data),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .level_o (level),
    .full_o  (full)
  );

  always_comb begin
    stop_len_w = '0;
    case (stopbits_e'(bus.stopbits))
      STOP_0P5: stop_len_w = {1'b0, bus.bit_duration >> 1};
      STOP_1:   stop_len_w = {1'b0, bus.bit_duration};
      STOP_1P5: stop_len_w = {1'b0, bus.bit_duration} + {2'b00, bus.bit_duration[CNT_W-1:1]};
      STOP_2:   stop_len_w = {bus.bit_duration, 1'b0};
      default:  stop_len_w = {1'b0, bus.bit_duration};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (fifo_nonempty) state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA:   if (bit_end && last_bit) state_d = (par_mode_q == PAR_NONE) ? S_STOP : S_PARITY;
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP:   if (stop_end) state_d = fifo_nonempty ? S_START : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_w      = 1'b1;
    tx_done_w = 1'b0;
    busy_w    = (state_q != S_IDLE);
    case (state_q)
      S_START:  tx_w = 1'b0;
      S_DATA:   tx_w = msb_first_q ? shreg_q[DATA_W-1] : shreg_q[0];
      S_PARITY: tx_w = par_bit_q;
      S_STOP:   tx_done_w = stop_end;
      default:  tx_w = 1'b1;
    endcase
  end

  always_comb begin
    cnt_d  = '0;
    scnt_d = '0;
    idx_d  = '0;
    if (state_q inside {S_START, S_DATA, S_PARITY})
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    if (state_q == S_STOP && !stop_end)
      scnt_d = scnt_q + SW'(1);
    if (state_q == S_DATA)
      idx_d = !bit_end ? idx_q : (last_bit ? '0 : idx_q + IDX_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      scnt_q      <= '0;
      idx_q       <= '0;
      bd_q        <= '0;
      stop_len_q  <= '0;
      par_mode_q  <= PAR_NONE;
      msb_first_q <= 1'b0;
      shreg_q     <= '0;
      par_bit_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      scnt_q <= scnt_d;
      idx_q  <= idx_d;
      if (pop) begin
        bd_q        <= bus.bit_duration;
        stop_len_q  <= stop_len_w;
        par_mode_q  <= sanitize_parity(bus.parity_mode);
        msb_first_q <= bus.msb_first;
      end
      if (load_word) begin
        shreg_q   <= fifo_data;
        par_bit_q <= parity_bit(par_mode_q, ^fifo_data);
      end else if (state_q == S_DATA && bit_end) begin
        shreg_q <= msb_first_q ? {shreg_q[DATA_W-2:0], 1'b0} : {1'b0, shreg_q[DATA_W-1:1]};
      end
    end
  end

  assign bus.tx         = tx_w;
  assign bus.tx_done    = tx_done_w;
  assign bus.busy       = busy_w;
  assign bus.in_ready   = !full;
  assign bus.fifo_level = level;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
// ============================================================================
// Module  : tb_uart_tx_cfg
// Brief   : Directed self-checking bench for uart_tx_cfg.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_cfg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  uart_tx_cfg_if #(.DATA_W(8), .CNT_W(16), .FIFO_DEPTH(4)) bus ();

  uart_tx_cfg #(.DATA_W(8), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.tx === 1'b0) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check({tag, " start"}, 32'(found), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.tx_done === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check({tag, " done seen"}, 32'(found), 32'd1);
    tick();
  endtask

  // Entered on the first START cycle; bits[nbits-1] is the first level on the line.
  task automatic check_frame(input string tag, input logic [9:0] bits, input int nbits,
                             input int bd, input int stop_cyc);
    int bad = 0;
    int done_bad = 0;
    for (int i = 0; i < nbits; i++) begin
      for (int j = 0; j < bd; j++) begin
        if (bus.tx !== bits[nbits-1-i] || bus.busy !== 1'b1) bad++;
        if (bus.tx_done !== 1'b0) done_bad++;
        tick();
      end
    end
    for (int j = 0; j < stop_cyc; j++) begin
      if (bus.tx !== 1'b1 || bus.busy !== 1'b1) bad++;
      if (bus.tx_done !== (j == stop_cyc - 1)) done_bad++;
      tick();
    end
    check({tag, " line"}, 32'(bad), 32'd0);
    check({tag, " tx_done"}, 32'(done_bad), 32'd0);
  endtask

  initial begin
    int bad;
    bus.bit_duration = 16'd4;
    bus.parity_mode  = 3'd0;
    bus.stopbits     = 2'b01;
    bus.msb_first    = 1'b0;
    bus.in_data      = '0;
    bus.in_valid     = 1'b0;

    // Reset takes effect before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst tx", 32'(bus.tx), 32'd1);
    check("rst tx_done", 32'(bus.tx_done), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst level", 32'(bus.fifo_level), 32'd0);
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // 0xA5, no parity, 1 stop, LSB first; exact start latency.
    push_word(8'hA5);
    check("a5 level after push", 32'(bus.fifo_level), 32'd1);
    check("a5 idle before pop", 32'(bus.tx), 32'd1);
    tick();
    check("a5 start low", 32'(bus.tx), 32'd0);
    check("a5 busy", 32'(bus.busy), 32'd1);
    check("a5 level after pop", 32'(bus.fifo_level), 32'd0);
    check_frame("a5", 10'b0_10100101, 9, 4, 4);
    check("a5 idle after", 32'({bus.tx, bus.busy}), 32'b10);

    bus.parity_mode = 3'd1;
    push_word(8'h07);
    wait_start("even07");
    check_frame("even07", 10'b0_11100000_1, 10, 4, 4);

    bus.parity_mode = 3'd2;
    push_word(8'h07);
    wait_start("odd07");
    check_frame("odd07", 10'b0_11100000_0, 10, 4, 4);

    bus.parity_mode = 3'd0;
    bus.msb_first   = 1'b1;
    push_word(8'h80);
    wait_start("msb80");
    check_frame("msb80", 10'b0_10000000, 9, 4, 4);
    push_word(8'hB2);
    wait_start("msbB2");
    check_frame("msbB2", 10'b0_10110010, 9, 4, 4);

    bus.msb_first   = 1'b0;
    bus.parity_mode = 3'd3;
    bus.stopbits    = 2'b10;
    push_word(8'h3C);
    wait_start("mark stop1p5");
    check_frame("mark stop1p5", 10'b0_00111100_1, 10, 4, 6);

    bus.parity_mode = 3'd4;
    bus.stopbits    = 2'b00;
    push_word(8'hFF);
    wait_start("space stop0p5");
    check_frame("space stop0p5", 10'b0_11111111_0, 10, 4, 2);

    bus.parity_mode = 3'd7;
    bus.stopbits    = 2'b11;
    push_word(8'h01);
    wait_start("rsvd stop2");
    check_frame("rsvd stop2", 10'b0_10000000, 9, 4, 8);

    // One frame in flight, then overfill the buffer: 4 accepted, 5th dropped.
    bus.parity_mode = 3'd0;
    bus.stopbits    = 2'b01;
    push_word(8'h11);
    push_word(8'h12);
    push_word(8'hC1);
    push_word(8'h0F);
    check("fill ready at 3", 32'(bus.in_ready), 32'd1);
    push_word(8'h36);
    check("fill ready at 4", 32'(bus.in_ready), 32'd0);
    check("fill level at 4", 32'(bus.fifo_level), 32'd4);
    push_word(8'hEE);
    check("fill level after drop", 32'(bus.fifo_level), 32'd4);
    wait_done("first frame");
    check_frame("b2b 12", 10'b0_01001000, 9, 4, 4);
    check_frame("b2b C1", 10'b0_10000011, 9, 4, 4);
    check_frame("b2b 0F", 10'b0_11110000, 9, 4, 4);
    check_frame("b2b 36", 10'b0_01101100, 9, 4, 4);
    check("b2b idle after", 32'({bus.tx, bus.busy, bus.fifo_level}), 32'b1_0_000);

    // Reset during DATA bit 3 with one more word buffered.
    push_word(8'hF0);
    push_word(8'h55);
    for (int i = 0; i < 15; i++) tick();
    check("abort pre tx", 32'(bus.tx), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("abort tx", 32'(bus.tx), 32'd1);
    check("abort level", 32'(bus.fifo_level), 32'd0);
    check("abort busy/done", 32'({bus.busy, bus.tx_done}), 32'd0);
    tick();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.tx !== 1'b1 || bus.tx_done !== 1'b0 || bus.busy !== 1'b0) bad++;
      tick();
    end
    check("post-abort quiet", 32'(bad), 32'd0);
    push_word(8'h12);
    wait_start("post-abort");
    check_frame("post-abort", 10'b0_01001000, 9, 4, 4);

    // Parity change after the first pop only affects the following frame.
    bus.parity_mode = 3'd1;
    push_word(8'h07);
    push_word(8'h07);
    bus.parity_mode = 3'd2;
    check("midchg in frame", 32'(bus.tx), 32'd0);
    check_frame("midchg even", 10'b0_11100000_1, 10, 4, 4);
    check_frame("midchg odd", 10'b0_11100000_0, 10, 4, 4);
    check("midchg idle", 32'({bus.tx, bus.busy}), 32'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
